// File: rtl/y86_mem_pkg.sv
// Shared definitions for the Y86-64 data-memory responder: FSM states,
// status codes reported by the memory stage, default geometry and counter width.
package y86_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Status codes the requester derives from resp_err.
    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_ADR = 2'b11;

    localparam int DEFAULT_DEPTH = 256;

    // Latency counter width; covers LATENCY values 1..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous 64-bit RAM. Writes commit on the enabled edge;
// reads register the word into rdata, which holds until the next enabled read.
module dmem_array #(
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);

    logic [63:0] r_mem [DEPTH];
    logic [63:0] r_rdata;

    // Storage is deliberately not reset so contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= wdata;
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage slave for the Y86-64 pipeline. One transaction at a time:
// accept in IDLE, count out LATENCY-1 cycles in WAIT, access the array on the
// edge that enters RESP, then hold the response until the requester takes it.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where
// resp_valid and resp_ready are both 1. req_ready is high only in IDLE, so a
// requester must hold its request (valid and payload) until it transfers.
module dmem_responder
    import y86_mem_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output state_t      dbg_state
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [63:0]      r_addr;
    logic [63:0]      r_wdata;
    logic             r_err;
    logic             r_rd_ok;

    logic             w_accept;
    logic             w_go_resp;
    logic             w_acc_we;
    logic [63:0]      w_acc_addr;
    logic [63:0]      w_acc_wdata;
    logic             w_acc_err;
    logic             w_ram_en;
    logic [63:0]      w_ram_rdata;

    assign w_accept = req_valid && (r_state == IDLE);

    // The array is touched on the edge that enters RESP. With LATENCY==1 that
    // is the acceptance edge itself, so the live request feeds the array;
    // otherwise the latched copy does.
    assign w_go_resp   = (r_state == IDLE) ? (w_accept && (LATENCY == 1))
                                           : ((r_state == WAIT) && (r_cnt == CNT_ONE));
    assign w_acc_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

    // Full 64-bit range check: high address bits must never alias onto the array.
    assign w_acc_err = (w_acc_addr >= 64'(DEPTH));

    // rst_n gating keeps a request held through reset from touching the array.
    assign w_ram_en = w_go_resp && !w_acc_err && rst_n;

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .en    (w_ram_en),
        .we    (w_acc_we),
        .addr  (w_acc_addr[AW-1:0]),
        .wdata (w_acc_wdata),
        .rdata (w_ram_rdata)
    );

    // Next-state selection for the IDLE -> WAIT -> RESP -> IDLE cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (r_cnt == CNT_ONE) w_state_nxt = RESP;
            RESP:    if (resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, request latch, latency counter and response status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_rd_ok <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt   <= CNT_LOAD;
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_go_resp) begin
                r_err   <= w_acc_err;
                r_rd_ok <= !w_acc_err && !w_acc_we;
            end
        end
    end

    // The array's registered rdata only changes on an enabled read, so it is
    // stable for the whole RESP stay; it is shown only for successful reads.
    assign req_ready  = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = (resp_valid && r_rd_ok) ? w_ram_rdata : 64'd0;
    assign busy       = (r_state != IDLE);
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance exercised with directed and
// random transactions against a word-array model, plus a LATENCY=1 instance
// checked for one-cycle response and two-cycle throughput.
module tb_dmem_responder;
    import y86_mem_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT (LATENCY=2) ----------------
    logic        req_valid  = 1'b0;
    logic        req_we     = 1'b0;
    logic [63:0] req_addr   = '0;
    logic [63:0] req_wdata  = '0;
    logic        resp_ready = 1'b0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [63:0] resp_rdata;
    state_t      dbg_state;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- second DUT (LATENCY=1) ----------------
    logic        req_valid1  = 1'b0;
    logic        req_we1     = 1'b0;
    logic [63:0] req_addr1   = '0;
    logic [63:0] req_wdata1  = '0;
    logic        resp_ready1 = 1'b0;
    logic        req_ready1, resp_valid1, resp_err1, busy1;
    logic [63:0] resp_rdata1;
    state_t      dbg_state1;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1),
        .busy(busy1), .dbg_state(dbg_state1)
    );

    // ---------------- scoreboard / model ----------------
    int          n_vec = 0;
    int          n_err = 0;
    logic [64:0] exp_q[$];      // {err, rdata}
    bit          known_q[$];    // rdata is defined (word written earlier)
    logic [63:0] mem_m [DEPTH];
    bit          known_m [DEPTH];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural memory: the response a request earns, in acceptance order.
    task automatic model_apply(input logic we, input logic [63:0] addr, input logic [63:0] wd);
        if (addr >= 64'(DEPTH)) begin
            exp_q.push_back({1'b1, 64'd0});
            known_q.push_back(1'b1);
        end else if (we) begin
            mem_m[int'(addr)]   = wd;
            known_m[int'(addr)] = 1'b1;
            exp_q.push_back({1'b0, 64'd0});
            known_q.push_back(1'b1);
        end else begin
            exp_q.push_back({1'b0, mem_m[int'(addr)]});
            known_q.push_back(known_m[int'(addr)]);
        end
    endtask

    // ---------------- driver tasks (enter and leave just after a negedge) ----------------
    task automatic accept(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                          input bit use_model);
        int cyc = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready_before_accept", 64'(req_ready), 64'd1);
        @(posedge clk);
        if (use_model) model_apply(we, addr, wd);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int lat = 1;
        while (!resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(LAT));
    endtask

    task automatic collect(input int hold);
        logic [63:0] d0;
        logic        e0;
        logic [64:0] exp;
        bit          kn;
        d0 = resp_rdata;
        e0 = resp_err;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_valid",     64'(resp_valid), 64'd1);
            check("bp_rdata",     resp_rdata,      d0);
            check("bp_err",       64'(resp_err),   64'(e0));
            check("bp_busy",      64'(busy),       64'd1);
            check("bp_req_ready", 64'(req_ready),  64'd0);
        end
        check("resp_valid", 64'(resp_valid), 64'd1);
        check("exp_q_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            kn  = known_q.pop_front();
            check("resp_err", 64'(resp_err), 64'(exp[64]));
            if (kn) check("resp_rdata", resp_rdata, exp[63:0]);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_released", 64'(resp_valid), 64'd0);
    endtask

    task automatic xact(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                        input int hold);
        accept(we, addr, wd, 1'b1);
        wait_resp();
        collect(hold);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_req_ready"},  64'(req_ready),  64'd1);
        check({pfx, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({pfx, "_resp_rdata"}, resp_rdata,      64'd0);
        check({pfx, "_resp_err"},   64'(resp_err),   64'd0);
        check({pfx, "_busy"},       64'(busy),       64'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] a;
        logic [63:0] last1;
        logic [63:0] wd1;
        logic        we1;
        int          r;
        last1 = '0;
        for (int i = 0; i < DEPTH; i++) known_m[i] = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        check("rst1_req_ready",  64'(req_ready1),  64'd1);
        check("rst1_resp_valid", 64'(resp_valid1), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read
        xact(1'b1, 64'd5, 64'hDEAD_BEEF_0123_4567, 0);
        xact(1'b0, 64'd5, 64'd0, 0);

        // Range boundary
        xact(1'b1, 64'd0,   64'h0123_0000_AAAA_5555, 0);
        xact(1'b1, 64'd255, 64'hFFEE_DDCC_BBAA_9988, 0);
        xact(1'b0, 64'd256, 64'd0, 0);
        xact(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
        xact(1'b1, 64'd256, 64'h5A5A_5A5A_5A5A_5A5A, 0);
        xact(1'b1, 64'h8000_0000_0000_0000, 64'hA5A5_A5A5_A5A5_A5A5, 0);
        xact(1'b0, 64'h8000_0000_0000_0000, 64'd0, 0);
        xact(1'b0, 64'd0,   64'd0, 0);
        xact(1'b0, 64'd255, 64'd0, 0);

        // Backpressure: hold the response for 10 cycles
        xact(1'b0, 64'd5, 64'd0, 10);

        // Request while busy
        accept(1'b0, 64'd5, 64'd0, 1'b1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 64'd20;
        req_wdata = 64'h1111_2222_3333_4444;
        check("busy_wait_state", 64'(dbg_state), 64'(WAIT));
        check("busy_req_ready",  64'(req_ready), 64'd0);
        check("busy_busy",       64'(busy),      64'd1);
        wait_resp();
        check("busy_resp_req_ready", 64'(req_ready), 64'd0);
        collect(2);
        check("busy_not_taken_early", 64'(dbg_state), 64'(IDLE));
        accept(1'b1, 64'd20, 64'h1111_2222_3333_4444, 1'b1);
        wait_resp();
        collect(0);
        xact(1'b0, 64'd20, 64'd0, 0);

        // Reset mid-operation drops an uncommitted write
        xact(1'b1, 64'd9, 64'h7, 0);
        accept(1'b1, 64'd9, 64'h1, 1'b0);
        check("midrst_in_wait", 64'(dbg_state), 64'(WAIT));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(1'b0, 64'd9, 64'd0, 0);

        // Random traffic: preload a window, then mixed legal/illegal accesses
        for (int i = 32; i < 40; i++) xact(1'b1, 64'(i), {$urandom, $urandom}, 0);
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      a = 64'($urandom_range(32, 39));
            else if (r < 8) a = 64'(DEPTH + $urandom_range(0, 40));
            else            a = {1'b1, 31'($urandom), 32'($urandom)};
            xact(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, $urandom_range(0, 3));
        end

        // LATENCY=1 instance: alternating write/read of addr 0, resp_ready held high
        resp_ready1 = 1'b1;
        for (int t = 0; t < 6; t++) begin
            check("l1_req_ready",  64'(req_ready1),  64'd1);
            check("l1_idle_valid", 64'(resp_valid1), 64'd0);
            we1 = (t % 2 == 0);
            wd1 = {$urandom, $urandom};
            req_valid1 = 1'b1;
            req_we1    = we1;
            req_addr1  = 64'd0;
            req_wdata1 = wd1;
            if (we1) last1 = wd1;
            @(negedge clk);
            check("l1_resp_valid", 64'(resp_valid1), 64'd1);
            check("l1_busy_ready", 64'(req_ready1),  64'd0);
            check("l1_resp_err",   64'(resp_err1),   64'd0);
            check("l1_resp_rdata", resp_rdata1,      we1 ? 64'd0 : last1);
            @(negedge clk);
        end
        req_valid1  = 1'b0;
        resp_ready1 = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
